// File: rtl/irq_request_ctrl.sv
// irq_request_ctrl
//   External-interrupt front end for the pipelined MIPS core. A raw, bouncing
//   push-button is synchronized and debounced, and each press becomes a pending
//   request. ir_out stays high until the core acknowledges entry to the handler.
//   Further requests are then held back until the handler returns via ERET.
//
//   Build option: define IRQ_DEBOUNCE_EN to enable the debounce counter.
//   Without it the synchronized button drives the debounced level directly,
//   which suits simulation and clean sources such as a timer strobe.
//
// Ports:
//   clk         main clock
//   rst         asynchronous, active-high reset; clears all state
//   btn_irq     raw asynchronous button, active-high
//   irq_mask    1 = hold ir_out low (presses are still counted)
//   irq_ack     one-cycle pulse from the core when the interrupt jump is taken
//   irq_ret     one-cycle pulse from the core when ERET retires
//   ir_out      registered interrupt request to the core's ir_in
//   in_service  registered, high while the handler runs
//   pending     registered count of unserviced presses (saturating)
module irq_request_ctrl #(
  parameter int DB_WIDTH   = 20,
  parameter int DB_CYCLES  = 1000000,
  parameter int PEND_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_irq,
  input  logic                  irq_mask,
  input  logic                  irq_ack,
  input  logic                  irq_ret,
  output logic                  ir_out,
  output logic                  in_service,
  output logic [PEND_WIDTH-1:0] pending
);

  // Encoding puts REQ and SERVICE on their own bits so both outputs come
  // straight from state flops with no decode logic.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  state_t                state;
  state_t                state_next;
  logic                  sync_meta;
  logic                  btn_s;
  logic                  db_lvl;
  logic                  db_prev;
  logic                  press;
  logic                  ack_taken;
  logic [PEND_WIDTH-1:0] pend_next;

  if (DB_CYCLES < 1 || DB_CYCLES > (2 ** DB_WIDTH) - 1) begin : g_bad_cfg
    $error("irq_request_ctrl: DB_CYCLES does not fit in DB_WIDTH");
  end

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      sync_meta <= btn_irq;
      btn_s     <= sync_meta;
    end
  end

`ifdef IRQ_DEBOUNCE_EN
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_CYCLES - 1);

  logic [DB_WIDTH-1:0] db_cnt;

  // The level only flips after DB_CYCLES consecutive samples that disagree
  // with it; any sample that agrees restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_lvl <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_lvl <= ~db_lvl;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_WIDTH'(1);
    end
  end
`else
  assign db_lvl = btn_s;
`endif

  // One-cycle press pulse on the rising edge of the debounced level only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= 1'b0;
      press   <= 1'b0;
    end else begin
      db_prev <= db_lvl;
      press   <= db_lvl & ~db_prev;
    end
  end

  // An ack only counts while a request is actually being presented. A press
  // and an accepted ack in the same cycle cancel out.
  always_comb begin
    ack_taken = (state == REQ) && irq_ack;
    pend_next = pending;
    if (press && !ack_taken && (pending != PEND_MAX)) begin
      pend_next = pending + PEND_WIDTH'(1);
    end else if (ack_taken && !press && (pending != '0)) begin
      pend_next = pending - PEND_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pend_next;
    end
  end

  // Ack wins over a mask rising in the same cycle: the core has already
  // taken the jump. ERET with more work queued goes straight back to REQ.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if ((pend_next != '0) && !irq_mask) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_next = SERVICE;
        end else if (irq_mask) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (irq_ret) begin
          if ((pend_next != '0) && !irq_mask) begin
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ir_out     = state[0];
  assign in_service = state[1];

endmodule

// File: tb/tb_irq_request_ctrl.sv
// tb_irq_request_ctrl
//   Self-checking bench for irq_request_ctrl. A behavioural model follows the
//   button history, the press count and the request/service phase; the DUT
//   outputs are compared to it on every falling clock edge. Directed scenarios
//   add literal expectations, then a randomized phase exercises everything.
module tb_irq_request_ctrl;

  localparam int DB   = 4;
  localparam int PW   = 3;
  localparam int PMAX = (1 << PW) - 1;
  localparam int HD   = 16;
`ifdef IRQ_DEBOUNCE_EN
  localparam int LAT = DB + 4;
`else
  localparam int LAT = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_irq = 1'b0;
  logic          irq_mask = 1'b0;
  logic          irq_ack = 1'b0;
  logic          irq_ret = 1'b0;
  logic          ir_out;
  logic          in_service;
  logic [PW-1:0] pending;

  int checks = 0;
  int errors = 0;

  irq_request_ctrl #(
    .DB_WIDTH  (4),
    .DB_CYCLES (DB),
    .PEND_WIDTH(PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_irq   (btn_irq),
    .irq_mask  (irq_mask),
    .irq_ack   (irq_ack),
    .irq_ret   (irq_ret),
    .ir_out    (ir_out),
    .in_service(in_service),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Model state: hist[0] is the button value sampled at the previous edge,
  // hist[k] the one k edges before that.
  logic [HD-1:0] hist;
  logic          m_press;
  logic          m_req;
  logic          m_svc;
  int            m_pend;
`ifdef IRQ_DEBOUNCE_EN
  logic          m_lvl;
  logic          m_lvl_d;
`endif

  // True when the last DB samples seen by the debouncer all disagree with lvl.
  function automatic logic window_differs(input logic [HD-1:0] h, input logic lvl);
    for (int i = 1; i <= DB; i++) begin
      if (h[i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int next_pend(input int p, input logic pr, input logic acc);
    int n;
    n = p + int'(pr) - int'(acc);
    if (n > PMAX) n = PMAX;
    if (n < 0) n = 0;
    return n;
  endfunction

  // Returns {request, in_service} after this edge.
  function automatic logic [1:0] next_phase(input logic req, input logic svc, input int p,
                                            input logic mask, input logic ack, input logic ret);
    if (req) begin
      if (ack) return 2'b01;
      if (mask) return 2'b00;
      return 2'b10;
    end
    if (svc) begin
      if (!ret) return 2'b01;
      return (p > 0 && !mask) ? 2'b10 : 2'b00;
    end
    return (p > 0 && !mask) ? 2'b10 : 2'b00;
  endfunction

  // Reference model, advanced on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= '0;
      m_press <= 1'b0;
      m_req   <= 1'b0;
      m_svc   <= 1'b0;
      m_pend  <= 0;
`ifdef IRQ_DEBOUNCE_EN
      m_lvl   <= 1'b0;
      m_lvl_d <= 1'b0;
`endif
    end else begin
      hist <= {hist[HD-2:0], btn_irq};
`ifdef IRQ_DEBOUNCE_EN
      m_lvl   <= window_differs(hist, m_lvl) ? ~m_lvl : m_lvl;
      m_lvl_d <= m_lvl;
      m_press <= m_lvl & ~m_lvl_d;
`else
      m_press <= hist[1] & ~hist[2];
`endif
      m_pend <= next_pend(m_pend, m_press, m_req & irq_ack);
      {m_req, m_svc} <= next_phase(m_req, m_svc, next_pend(m_pend, m_press, m_req & irq_ack),
                                   irq_mask, irq_ack, irq_ret);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model.
  always @(negedge clk) begin
    checkOutput("model_ir_out", {31'd0, ir_out}, {31'd0, m_req});
    checkOutput("model_in_service", {31'd0, in_service}, {31'd0, m_svc});
    checkOutput("model_pending", {29'd0, pending}, m_pend);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic b, input logic m, input logic a, input logic r,
                               input int cycles);
    btn_irq  = b;
    irq_mask = m;
    irq_ack  = a;
    irq_ret  = r;
    step(cycles);
    irq_ack = 1'b0;
    irq_ret = 1'b0;
  endtask

  task automatic pressOnce(input logic m);
    applyStimulus(1'b1, m, 1'b0, 1'b0, LAT + 1);
    applyStimulus(1'b0, m, 1'b0, 1'b0, LAT + 1);
  endtask

  // Counts edges from the first edge sampling the current inputs until ir_out rises.
  task automatic measureLatency(input string name);
    int edges;
    edges = 0;
    while (ir_out !== 1'b1 && edges < 64) begin
      @(posedge clk);
      edges++;
      #1;
    end
    checkOutput(name, edges, LAT);
  endtask

  initial begin
    int hold;
    logic b;
    logic m;
    #1 rst = 1'b1;
    step(2);
    checkOutput("reset_ir_out", {31'd0, ir_out}, 0);
    checkOutput("reset_in_service", {31'd0, in_service}, 0);
    checkOutput("reset_pending", {29'd0, pending}, 0);
    rst = 1'b0;
    step(2);

    // Latency from a held button, then ack.
    btn_irq = 1'b1;
    measureLatency("latency_first_press");
    checkOutput("t1_pending", {29'd0, pending}, 1);
    step(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("t1_ack_ir_out", {31'd0, ir_out}, 0);
    checkOutput("t1_ack_in_service", {31'd0, in_service}, 1);
    checkOutput("t1_ack_pending", {29'd0, pending}, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, LAT + 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("t1_ret_in_service", {31'd0, in_service}, 0);

`ifdef IRQ_DEBOUNCE_EN
    // Short bursts never reach the debounce threshold.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, LAT + 2);
    checkOutput("t2_glitch_ir_out", {31'd0, ir_out}, 0);
    checkOutput("t2_glitch_pending", {29'd0, pending}, 0);
`endif

    // Queue presses during service and drain them with ack/ret pairs.
    pressOnce(1'b0);
    checkOutput("t3_req", {31'd0, ir_out}, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 9; i++) pressOnce(1'b0);
    checkOutput("t3_saturated", {29'd0, pending}, 7);
    checkOutput("t3_still_service", {31'd0, in_service}, 1);
    for (int k = 6; k >= 0; k--) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
      checkOutput("t3_ret_reassert", {31'd0, ir_out}, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
      checkOutput("t3_drain_pending", {29'd0, pending}, k);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    step(3);
    checkOutput("t3_idle_ir_out", {31'd0, ir_out}, 0);
    checkOutput("t3_idle_in_service", {31'd0, in_service}, 0);

    // Masked press, unmask, re-mask, stray ack while idle.
    pressOnce(1'b1);
    checkOutput("t4_masked_pending", {29'd0, pending}, 1);
    checkOutput("t4_masked_ir_out", {31'd0, ir_out}, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("t4_unmask_ir_out", {31'd0, ir_out}, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("t4_remask_ir_out", {31'd0, ir_out}, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("t4_stray_ack_pending", {29'd0, pending}, 1);
    checkOutput("t4_stray_ack_in_service", {31'd0, in_service}, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("t4_req_again", {31'd0, ir_out}, 1);

    // Press pulse lands on the same edge as the ack.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, LAT - 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("t5_coincident_pending", {29'd0, pending}, 1);
    checkOutput("t5_coincident_in_service", {31'd0, in_service}, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, LAT + 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("t5_ret_ir_out", {31'd0, ir_out}, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("t5_ack_pending", {29'd0, pending}, 0);

    // Asynchronous reset while in service with work queued.
    for (int i = 0; i < 3; i++) pressOnce(1'b0);
    checkOutput("t6_pending", {29'd0, pending}, 3);
    checkOutput("t6_in_service", {31'd0, in_service}, 1);
    btn_irq = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_async_ir_out", {31'd0, ir_out}, 0);
    checkOutput("t6_async_in_service", {31'd0, in_service}, 0);
    checkOutput("t6_async_pending", {29'd0, pending}, 0);
    step(1);
    rst = 1'b0;
    measureLatency("latency_after_reset");
    step(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, LAT + 2);

    // Randomized traffic checked only by the model.
    hold = 0;
    b = 1'b0;
    m = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        b = ~b;
        hold = $urandom_range(1, LAT + 3);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) m = ~m;
      applyStimulus(b, m, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_request_ctrl.md
# irq_request_ctrl

External-interrupt front end feeding the pipelined MIPS core's `ir_in` request line. It synchronizes and debounces a raw push-button, turns each debounced press into a pending request, and holds `ir_out` high until the core acknowledges entry to the handler. It then blocks further requests until the handler returns. The block sits between the board I/O and the core's CP0 interrupt input.

## Interface
Parameters:
- `DB_WIDTH`, 20: width of the debounce counter.
- `DB_CYCLES`, 1000000: consecutive stable samples required to accept a level change (10 ms at 100 MHz); must be ≥1 and < 2^DB_WIDTH.
- `PEND_WIDTH`, 3: width of the pending-request counter; saturates at 2^PEND_WIDTH−1.

Ports:
- `clk`  in  1  main clock.
- `rst`  in  1  reset, asynchronous and active-high; one clock; all state is cleared on assertion.
- `btn_irq`  in  1  raw, asynchronous, bouncing button; active-high.
- `irq_mask`  in  1  1 = suppress `ir_out`; presses are still counted.
- `irq_ack`  in  1  one-cycle pulse from the core when the interrupt jump is taken.
- `irq_ret`  in  1  one-cycle pulse from the core when ERET retires.
- `ir_out`  out  1  registered interrupt request, connected to the core's `ir_in`.
- `in_service`  out  1  registered; high while the handler is running.
- `pending`  out  PEND_WIDTH  registered count of unserviced presses.

## Operation
- **Synchronizer:** 2-flop on `btn_irq`, producing `btn_s`.
- **Debounce:**
  - Register `db_lvl`, counter `db_cnt`.
  - If `btn_s == db_lvl`, then `db_cnt <= 0`.
  - Otherwise `db_cnt` increments. When it reaches `DB_CYCLES−1`, `db_lvl` toggles and `db_cnt <= 0`.
  - Any glitch back to `db_lvl` restarts the count.
- **Edge detect:** `press` is a one-cycle registered pulse on the 0→1 transition of `db_lvl`. Releases produce nothing.
- **Pending counter:**
  - `+1` on `press`, `−1` on an accepted ack. Both in the same cycle leaves it unchanged.
  - Saturates at the maximum; extra presses are dropped.
  - Never underflows.
- **FSM** (states IDLE, REQ, SERVICE):
  - IDLE → REQ when next-state pending > 0 and `irq_mask == 0`.
  - REQ → SERVICE on `irq_ack`; this is the accepted ack and decrements pending.
  - REQ → IDLE if `irq_mask` rises before ack; pending is kept.
  - SERVICE → REQ on `irq_ret` if pending (after the update) > 0 and unmasked; otherwise SERVICE → IDLE.
- **Ignored inputs:**
  - `irq_ack` outside REQ.
  - `irq_ret` outside SERVICE.
  - Simultaneous ack and ret: only the input relevant to the current state acts.
- **Outputs:** `ir_out = (state == REQ)` and `in_service = (state == SERVICE)`, both registered state bits.

## Timing
- **Reset values:**
  - `ir_out = 0`, `in_service = 0`, `pending = 0`, state IDLE.
  - Synchronizer flops, `db_lvl`, `db_cnt` and `press` all 0.
- **Reset mid-operation:** any queued or in-service request is discarded. After release the block restarts from IDLE, and a button still held re-debounces from `db_lvl = 0`.
- **Latency:**
  - `btn_s` follows a sampled `btn_irq` rise after 2 edges.
  - `db_lvl` rises after `DB_CYCLES` further edges of stable input.
  - `press` follows 1 edge later; `pending` and the state update on the edge where `press = 1`.
  - Total: `ir_out` rises exactly `DB_CYCLES + 4` edges after the first edge that samples `btn_irq = 1`, provided the block is IDLE and unmasked.
- **Ack:** `ir_out` falls and `in_service` rises on the edge that samples `irq_ack`.
- **Ret:** `ir_out` re-asserts on the edge that samples `irq_ret` when requests are still pending. There is no idle gap.
- **Mask:** `ir_out` follows `irq_mask` with 1 cycle of latency. Unmasking with pending > 0 enters REQ on the next edge.

## Configuration
- **`IRQ_DEBOUNCE_EN` defined:** debounce stage as described.
- **`IRQ_DEBOUNCE_EN` undefined:**
  - `db_lvl` is driven directly by `btn_s`; `db_cnt` and `DB_CYCLES` are unused.
  - Latency becomes exactly 4 edges.
  - Intended for simulation and for clean sources such as a timer strobe.

## Test plan
Unless noted, `DB_CYCLES = 4`, `PEND_WIDTH = 3` and `IRQ_DEBOUNCE_EN` is defined.
1. **Latency:** reset, then hold `btn_irq = 1` → `ir_out` rises exactly 8 edges later and `pending == 1`. Pulse `irq_ack` → `ir_out = 0`, `in_service = 1`, `pending == 0`.
2. **Glitch rejection:** `btn_irq` high for 3 cycles, low 1, high 3, low → `ir_out` stays 0 and `pending` stays 0 throughout.
3. **Back-to-back service:** 9 clean presses while in SERVICE → `pending` saturates at 7. Each ack/ret pair decrements it; `ir_out` re-asserts on the `irq_ret` edge each time until `pending == 0`, then the block stays IDLE.
4. **Mask:** press with `irq_mask = 1` → `pending == 1`, `ir_out = 0`. Drop the mask → `ir_out = 1` one edge later. Stray `irq_ack` while IDLE → no change.
5. **Press coincident with ack:** `press` and `irq_ack` in the same cycle with `pending == 1` → `pending` stays 1, `in_service = 1`. The following `irq_ret` → `ir_out = 1`.
6. **Reset in service:** assert `rst` asynchronously while `in_service = 1` and `pending == 3` → all outputs are 0 immediately, before the next clock edge. With `IRQ_DEBOUNCE_EN` undefined, a press → `ir_out` rises 4 edges later.
